// File: rtl/vx_issue_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : vx_issue_sched_if
// Purpose : Queue-head, issue-slot and next-warp hint bundle for the warp scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface vx_issue_sched_if #(
   parameter int NUM_WARPS = 4,
   parameter int NW_BITS   = $clog2(NUM_WARPS)
);
   logic [NUM_WARPS-1:0] head_valid;
   logic [NUM_WARPS-1:0] head_stall;
   logic [NUM_WARPS-1:0] deq;
   logic                 out_valid;
   logic [NW_BITS-1:0]   out_wid;
   logic                 out_ready;
   logic [NW_BITS-1:0]   wid_n;
   logic                 prefetch;

   modport master (
      output head_valid, head_stall, out_ready,
      input  deq, out_valid, out_wid, wid_n, prefetch
   );

   modport slave (
      input  head_valid, head_stall, out_ready,
      output deq, out_valid, out_wid, wid_n, prefetch
   );
endinterface
`default_nettype wire

// File: rtl/vx_issue_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : vx_issue_sched
// Purpose : Greedy-then-round-robin warp picker feeding a registered issue slot.
// Revision: 1.0
// ---------------------------------------------------------------------------
module vx_issue_sched #(
   parameter int NUM_WARPS = 4,
   parameter int NW_BITS   = $clog2(NUM_WARPS),
   parameter int MAX_BURST = 4
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   vx_issue_sched_if.slave bus
);
   localparam int                    BURST_BITS  = $clog2(MAX_BURST + 1);
   localparam logic [BURST_BITS-1:0] BURST_LIMIT = BURST_BITS'(MAX_BURST);

   logic [NUM_WARPS-1:0]  elig;
   logic                  load;
   logic                  grant;
   logic                  issue;
   logic                  greedy;
   logic                  rr_found;
   logic [NW_BITS-1:0]    rr_cand;
   logic [NW_BITS-1:0]    rr_sel;
   logic [NW_BITS-1:0]    sel;
   logic [NW_BITS-1:0]    last_wid;
   logic [BURST_BITS-1:0] burst;
   logic                  slot_valid;
   logic [NW_BITS-1:0]    slot_wid;

   assign elig  = bus.head_valid & ~bus.head_stall;
   assign load  = ~slot_valid | bus.out_ready;
   assign grant = load & (|elig);
   assign issue = grant & rst_n;

   // burst==0 means no burst is in progress, so the first grant after reset
   // or an idle cycle always goes through the rotation.
   assign greedy = elig[last_wid] && (burst != '0) && (burst < BURST_LIMIT);

   // Rotation visits last_wid+1 first and last_wid itself last.
   always_comb begin
      rr_sel   = last_wid;
      rr_cand  = last_wid;
      rr_found = 1'b0;
      for (int i = 1; i <= NUM_WARPS; i++) begin
         rr_cand = last_wid + NW_BITS'(i);
         if (!rr_found && elig[rr_cand]) begin
            rr_sel   = rr_cand;
            rr_found = 1'b1;
         end
      end
   end

   assign sel = greedy ? last_wid : rr_sel;

   generate
      for (genvar w = 0; w < NUM_WARPS; w++) begin : g_deq
         assign bus.deq[w] = issue && (sel == NW_BITS'(w));
      end
   endgenerate

   assign bus.wid_n     = issue ? sel : '0;
   assign bus.prefetch  = issue;
   assign bus.out_valid = slot_valid;
   assign bus.out_wid   = slot_wid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid <= 1'b0;
         slot_wid   <= '0;
         last_wid   <= NW_BITS'(NUM_WARPS - 1);
         burst      <= '0;
      end else if (grant) begin
         slot_valid <= 1'b1;
         slot_wid   <= sel;
         last_wid   <= sel;
         burst      <= greedy ? burst + 1'b1 : BURST_BITS'(1);
      end else if (load) begin
         slot_valid <= 1'b0;
         burst      <= '0;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_vx_issue_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_vx_issue_sched
// Purpose : Directed stimulus with an issue-slot scoreboard for vx_issue_sched.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vx_issue_sched;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   exp_q[$];

   vx_issue_sched_if #(.NUM_WARPS(4), .NW_BITS(2)) bus ();

   vx_issue_sched #(.NUM_WARPS(4), .NW_BITS(2), .MAX_BURST(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: drive inputs, check the combinational grant outputs, queue the expected issue.
   task automatic step(input logic [3:0] hv, input logic [3:0] hs, input logic rdy,
                       input logic g, input int wid);
      bus.head_valid = hv;
      bus.head_stall = hs;
      bus.out_ready  = rdy;
      #1;
      chk("prefetch", 32'(bus.prefetch), 32'(g));
      chk("deq", 32'(bus.deq), g ? (32'd1 << wid) : 32'd0);
      chk("wid_n", 32'(bus.wid_n), g ? 32'(wid) : 32'd0);
      if (g) exp_q.push_back(wid);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted issue slot is compared against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue got=%0d expected=none at %0t", bus.out_wid, $time);
            end else begin
               chk("out_wid", 32'(bus.out_wid), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.head_valid = 4'b1111;
      bus.head_stall = 4'b0000;
      bus.out_ready  = 1'b1;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_wid", 32'(bus.out_wid), 0);
      chk("rst_deq", 32'(bus.deq), 0);
      chk("rst_prefetch", 32'(bus.prefetch), 0);
      chk("rst_wid_n", 32'(bus.wid_n), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // All warps eligible: bursts of four, rotating 0,1,2
      for (int w = 0; w < 3; w++)
         for (int k = 0; k < 4; k++)
            step(4'b1111, 4'b0000, 1'b1, 1'b1, w);

      // Lone warp 0: issued every cycle across the forced rotation
      for (int k = 0; k < 6; k++)
         step(4'b0001, 4'b0000, 1'b1, 1'b1, 0);
      chk("no_gap_valid", 32'(bus.out_valid), 1);

      // Idle cycle clears the burst, then stall warp 1 after two grants
      step(4'b0000, 4'b0000, 1'b1, 1'b0, 0);
      chk("idle_valid_low", 32'(bus.out_valid), 0);
      step(4'b1111, 4'b0000, 1'b1, 1'b1, 1);
      step(4'b1111, 4'b0000, 1'b1, 1'b1, 1);
      step(4'b1111, 4'b0010, 1'b1, 1'b1, 2);
      step(4'b1111, 4'b0010, 1'b1, 1'b1, 2);

      // Backpressure holds warp 2 in the slot
      for (int k = 0; k < 3; k++) begin
         step(4'b1111, 4'b0000, 1'b0, 1'b0, 0);
         chk("held_valid", 32'(bus.out_valid), 1);
         chk("held_wid", 32'(bus.out_wid), 2);
      end
      step(4'b1111, 4'b0000, 1'b1, 1'b1, 2);

      // Nothing eligible, then only warp 2
      step(4'b0000, 4'b0000, 1'b1, 1'b0, 0);
      chk("empty_valid_low", 32'(bus.out_valid), 0);
      step(4'b0100, 4'b0000, 1'b1, 1'b1, 2);
      chk("w2_valid", 32'(bus.out_valid), 1);
      chk("w2_wid", 32'(bus.out_wid), 2);

      // Reset mid-burst drops the slot without a clock edge
      step(4'b1111, 4'b0000, 1'b1, 1'b1, 2);
      chk("pre_rst_valid", 32'(bus.out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.out_valid), 0);
      chk("async_rst_deq", 32'(bus.deq), 0);
      chk("async_rst_prefetch", 32'(bus.prefetch), 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++)
         step(4'b1111, 4'b0000, 1'b1, 1'b1, 0);
      step(4'b1111, 4'b0000, 1'b1, 1'b1, 1);

      step(4'b0000, 4'b0000, 1'b1, 1'b0, 0);
      chk("drain_empty", 32'(exp_q.size()), 0);
      chk("drain_valid", 32'(bus.out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
